sdram_wb_adapter: RTL and testbench
===================================

SDRAM_WB_ADAPTER -- requirements
Module: sdram_wb_adapter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, command FIFO entries (power of 2, 2..16).
REQ-002 SHALL have parameter MAX_OUTSTANDING, default 4, limit on commands accepted by the controller and not yet done (1..7).
REQ-003 SHALL have port clk  in  1  clock; all logic on its rising edge.
REQ-004 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-005 SHALL have ports wbs_cyc, wbs_stb, wbs_we  in  1 each  Wishbone pipelined-slave cycle, strobe, write-enable.
REQ-006 SHALL have ports wbs_adr  in  32 and wbs_dat_i  in  16  request address and write data.
REQ-007 SHALL have ports wbs_dat_o  out  16, wbs_ack  out  1, wbs_stall  out  1  read data, completion, back-pressure.
REQ-008 SHALL have ports sdram_access, sdram_cmd_ready, sdram_wr_rdn  out  1 each  to the SDRAM controller.
REQ-009 SHALL have ports sdram_addr  out  32 and sdram_wr_data  out  16  head-of-FIFO command fields.
REQ-010 SHALL have ports sdram_cmd_accepted, sdram_cmd_done  in  1 each, sdram_rd_data  in  16  from the controller.

Function
REQ-011 Push: wbs_cyc & wbs_stb & ~wbs_stall SHALL write {wbs_we, wbs_adr, wbs_dat_i} into the command FIFO in that cycle.
REQ-012 wbs_stall SHALL be combinational: FIFO full OR state == ST_DRAIN.
REQ-013 sdram_cmd_ready SHALL be (FIFO not empty) & (outstanding < MAX_OUTSTANDING) & state == ST_ACTIVE; sdram_addr/sdram_wr_rdn/sdram_wr_data SHALL show the head entry combinationally.
REQ-014 Pop: sdram_cmd_accepted while sdram_cmd_ready SHALL remove the head entry and increment outstanding; sdram_cmd_accepted with ready low SHALL be ignored.
REQ-015 sdram_cmd_done SHALL decrement outstanding; simultaneous pop and done SHALL leave outstanding unchanged; done with outstanding == 0 SHALL be ignored (no underflow, no ack).
REQ-016 Simultaneous push and pop on a non-full, non-empty FIFO SHALL keep occupancy unchanged; pointers wrap modulo FIFO_DEPTH.
REQ-017 In ST_ACTIVE, done SHALL produce wbs_ack = 1 one cycle later, with wbs_dat_o <= sdram_rd_data registered in the same edge (value don't-care for writes).
REQ-018 Acks SHALL be returned in request order, one per accepted request; min latency push -> ack = 1 (FIFO) + controller latency + 1.
REQ-019 sdram_access SHALL be registered: 1 while state == ST_ACTIVE or ST_DRAIN, else 0.
REQ-020 States: ST_IDLE, ST_ACTIVE, ST_DRAIN.
REQ-021 ST_IDLE -> ST_ACTIVE when wbs_cyc = 1 (push allowed in that same cycle).
REQ-022 ST_ACTIVE -> ST_IDLE when wbs_cyc = 0, FIFO empty and outstanding == 0.
REQ-023 ST_ACTIVE -> ST_DRAIN when wbs_cyc = 0 and (FIFO not empty or outstanding != 0); the FIFO SHALL be flushed on that edge.
REQ-024 ST_DRAIN: no pushes, sdram_cmd_ready = 0, dones decrement outstanding but wbs_ack SHALL stay 0; -> ST_IDLE when outstanding == 0.
REQ-025 wbs_ack SHALL never assert while wbs_cyc = 0.

Reset
REQ-026 On reset: state = ST_IDLE, FIFO empty, pointers 0, outstanding 0, wbs_ack 0, wbs_dat_o 16'h0000, sdram_access 0; hence sdram_cmd_ready 0, wbs_stall 0.
REQ-027 Reset mid-operation SHALL discard all queued and in-flight state; a done arriving after reset release SHALL be ignored per REQ-015.

Verification
REQ-028 Single read: push adr 32'h0000_0100, we = 0; controller accepts 2 cycles later, done 4 cycles after accept with rd_data 16'hBEEF -> ready held until accept, one wbs_ack the cycle after done, wbs_dat_o = 16'hBEEF.
REQ-029 Fill: 5 back-to-back writes, controller never accepts -> 4 pushed, wbs_stall = 1 from cycle after 4th push, 5th held; one accept -> stall drops next cycle, 5th pushes.
REQ-030 Outstanding limit: 6 queued reads, accepts every cycle, no done -> exactly 4 accepts then sdram_cmd_ready = 0; one done -> ready returns next cycle.
REQ-031 Abort: 3 queued, 1 in flight, drop wbs_cyc -> ST_DRAIN, FIFO empty, stall = 1, no ack on the following done, then ST_IDLE, sdram_access = 0.
REQ-032 Simultaneous pop + done + push with 2 queued, outstanding 1 -> occupancy 2, outstanding 1, one ack next cycle.
REQ-033 Async reset asserted with 2 queued and 1 outstanding -> all outputs at REQ-026 values immediately; a late done -> no ack.

Source files
------------

// File: rtl/sdram_wb_adapter.sv
// Bridges a pipelined Wishbone slave onto the SDRAM controller command handshake.
// Requests queue in a small FIFO; acks return in order as the controller reports completion.
module sdram_wb_adapter #(
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        wbs_cyc,
  input  logic        wbs_stb,
  input  logic        wbs_we,
  input  logic [31:0] wbs_adr,
  input  logic [15:0] wbs_dat_i,
  output logic [15:0] wbs_dat_o,
  output logic        wbs_ack,
  output logic        wbs_stall,
  output logic        sdram_access,
  output logic        sdram_cmd_ready,
  output logic        sdram_wr_rdn,
  output logic [31:0] sdram_addr,
  output logic [15:0] sdram_wr_data,
  input  logic        sdram_cmd_accepted,
  input  logic        sdram_cmd_done,
  input  logic [15:0] sdram_rd_data
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [2:0]       MAX_OUT  = 3'(MAX_OUTSTANDING);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACTIVE = 2'd1,
    ST_DRAIN  = 2'd2
  } state_t;

  state_t           state;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       outstanding;
  logic             ack_p1;

  logic             fifo_we  [FIFO_DEPTH];
  logic [31:0]      fifo_adr [FIFO_DEPTH];
  logic [15:0]      fifo_dat [FIFO_DEPTH];

  logic fifo_full;
  logic fifo_empty;
  logic out_zero;
  logic push;
  logic pop;
  logic done_v;
  logic flush;
  logic ack_set;

  assign fifo_full  = (cnt == FULL_CNT);
  assign fifo_empty = (cnt == '0);
  assign out_zero   = (outstanding == 3'd0);

  assign wbs_stall       = fifo_full | (state == ST_DRAIN);
  assign sdram_cmd_ready = ~fifo_empty & (outstanding < MAX_OUT) & (state == ST_ACTIVE);
  assign sdram_addr      = fifo_adr[rd_ptr];
  assign sdram_wr_rdn    = fifo_we[rd_ptr];
  assign sdram_wr_data   = fifo_dat[rd_ptr];

  assign push   = wbs_cyc & wbs_stb & ~wbs_stall;
  assign pop    = sdram_cmd_accepted & sdram_cmd_ready;
  assign done_v = sdram_cmd_done & ~out_zero;
  // Master leaving the cycle with work still pending abandons it: queue dropped, in-flight drained silently.
  assign flush  = (state == ST_ACTIVE) & ~wbs_cyc & ~(fifo_empty & out_zero);
  // A master that has dropped cyc has abandoned the cycle and must not see an ack.
  assign ack_set = done_v & (state == ST_ACTIVE) & wbs_cyc;
  assign wbs_ack = ack_p1 & wbs_cyc;

  // Stage p0: command storage, written on push
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_we[wr_ptr]  <= wbs_we;
      fifo_adr[wr_ptr] <= wbs_adr;
      fifo_dat[wr_ptr] <= wbs_dat_i;
    end
  end

  // Stage p1: control state, occupancy, in-flight count and registered completion
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      sdram_access <= 1'b0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      cnt          <= '0;
      outstanding  <= 3'd0;
      ack_p1       <= 1'b0;
      wbs_dat_o    <= 16'h0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (wbs_cyc) begin
            state        <= ST_ACTIVE;
            sdram_access <= 1'b1;
          end
        end
        ST_ACTIVE: begin
          if (!wbs_cyc) begin
            if (fifo_empty && out_zero) begin
              state        <= ST_IDLE;
              sdram_access <= 1'b0;
            end else begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (out_zero) begin
            state        <= ST_IDLE;
            sdram_access <= 1'b0;
          end
        end
        default: begin
          state        <= ST_IDLE;
          sdram_access <= 1'b0;
        end
      endcase

      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt    <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + 1'b1;
        if (pop)  rd_ptr <= rd_ptr + 1'b1;
        case ({push, pop})
          2'b10:   cnt <= cnt + 1'b1;
          2'b01:   cnt <= cnt - 1'b1;
          default: ;
        endcase
      end

      case ({pop, done_v})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: ;
      endcase

      ack_p1 <= ack_set;
      if (ack_set) wbs_dat_o <= sdram_rd_data;
    end
  end

endmodule

// File: tb/tb_sdram_wb_adapter.sv
// Directed bench for sdram_wb_adapter: read, fill, outstanding limit, combined
// pop/done/push, abort/drain and asynchronous reset.
module tb_sdram_wb_adapter;

  logic        clk = 1'b0;
  logic        reset;
  logic        wbs_cyc, wbs_stb, wbs_we;
  logic [31:0] wbs_adr;
  logic [15:0] wbs_dat_i;
  logic [15:0] wbs_dat_o;
  logic        wbs_ack, wbs_stall;
  logic        sdram_access, sdram_cmd_ready, sdram_wr_rdn;
  logic [31:0] sdram_addr;
  logic [15:0] sdram_wr_data;
  logic        sdram_cmd_accepted, sdram_cmd_done;
  logic [15:0] sdram_rd_data;

  int checks = 0;
  int errors = 0;
  logic exp_rdy [6] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  sdram_wb_adapter #(.FIFO_DEPTH(4), .MAX_OUTSTANDING(4)) dut (
    .clk                (clk),
    .reset              (reset),
    .wbs_cyc            (wbs_cyc),
    .wbs_stb            (wbs_stb),
    .wbs_we             (wbs_we),
    .wbs_adr            (wbs_adr),
    .wbs_dat_i          (wbs_dat_i),
    .wbs_dat_o          (wbs_dat_o),
    .wbs_ack            (wbs_ack),
    .wbs_stall          (wbs_stall),
    .sdram_access       (sdram_access),
    .sdram_cmd_ready    (sdram_cmd_ready),
    .sdram_wr_rdn       (sdram_wr_rdn),
    .sdram_addr         (sdram_addr),
    .sdram_wr_data      (sdram_wr_data),
    .sdram_cmd_accepted (sdram_cmd_accepted),
    .sdram_cmd_done     (sdram_cmd_done),
    .sdram_rd_data      (sdram_rd_data)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset = 1'b1;
    wbs_cyc = 1'b0; wbs_stb = 1'b0; wbs_we = 1'b0;
    wbs_adr = 32'h0; wbs_dat_i = 16'h0;
    sdram_cmd_accepted = 1'b0; sdram_cmd_done = 1'b0; sdram_rd_data = 16'h0;
    repeat (3) @(posedge clk);
    #1;
    chk1 ("rst_ack",    wbs_ack,         1'b0);
    chk16("rst_dat",    wbs_dat_o,       16'h0000);
    chk1 ("rst_access", sdram_access,    1'b0);
    chk1 ("rst_ready",  sdram_cmd_ready, 1'b0);
    chk1 ("rst_stall",  wbs_stall,       1'b0);
    reset = 1'b0;
    step();

    // single read
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b0; wbs_adr = 32'h0000_0100;
    settle();
    chk1("rd_stall_idle", wbs_stall, 1'b0);
    step();
    wbs_stb = 1'b0;
    settle();
    chk1 ("rd_access", sdram_access,    1'b1);
    chk1 ("rd_ready",  sdram_cmd_ready, 1'b1);
    chk32("rd_addr",   sdram_addr,      32'h0000_0100);
    chk1 ("rd_rdn",    sdram_wr_rdn,    1'b0);
    step();
    sdram_cmd_accepted = 1'b1;
    settle();
    chk1("rd_ready_held", sdram_cmd_ready, 1'b1);
    step();
    sdram_cmd_accepted = 1'b0;
    settle();
    chk1("rd_ready_popped", sdram_cmd_ready, 1'b0);
    chk1("rd_no_early_ack", wbs_ack,         1'b0);
    step(); step(); step();
    sdram_cmd_done = 1'b1; sdram_rd_data = 16'hBEEF;
    settle();
    chk1("rd_ack_before_done", wbs_ack, 1'b0);
    step();
    sdram_cmd_done = 1'b0; sdram_rd_data = 16'h0;
    settle();
    chk1 ("rd_ack", wbs_ack,   1'b1);
    chk16("rd_dat", wbs_dat_o, 16'hBEEF);
    step();
    chk1 ("rd_ack_single", wbs_ack,   1'b0);
    chk16("rd_dat_hold",   wbs_dat_o, 16'hBEEF);
    wbs_cyc = 1'b0;
    step();
    chk1("rd_idle_access", sdram_access, 1'b0);

    // fill: controller holds off, fifth write stalls
    wbs_cyc = 1'b1; wbs_stb = 1'b1; wbs_we = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wbs_adr = 32'h10 + i; wbs_dat_i = 16'(16'hA000 + i);
      settle();
      chk1("fill_stall_pre", wbs_stall, 1'b0);
      step();
    end
    wbs_adr = 32'h14; wbs_dat_i = 16'hA004;
    settle();
    chk1 ("fill_stall_full", wbs_stall,       1'b1);
    chk1 ("fill_ready",      sdram_cmd_ready, 1'b1);
    chk32("fill_head_addr",  sdram_addr,      32'h10);
    chk16("fill_head_data",  sdram_wr_data,   16'hA000);
    chk1 ("fill_head_rdn",   sdram_wr_rdn,    1'b1);
    step();
    sdram_cmd_accepted = 1'b1;
    settle();
    chk1("fill_stall_held", wbs_stall, 1'b1);
    step();
    sdram_cmd_accepted = 1'b0;
    settle();
    chk1 ("fill_stall_drop", wbs_stall,  1'b0);
    chk32("fill_head_next",  sdram_addr, 32'h11);
    step();
    wbs_stb = 1'b0;
    settle();
    chk1("fill_stall_refull", wbs_stall, 1'b1);
    sdram_cmd_accepted = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk32("fill_pop_order", sdram_addr, 32'h11 + i);
      step();
    end
    settle();
    chk1 ("fill_limit_ready", sdram_cmd_ready, 1'b0);
    chk32("fill_fifth_addr",  sdram_addr,      32'h14);
    chk16("fill_fifth_data",  sdram_wr_data,   16'hA004);
    step();
    chk32("fill_limit_hold", sdram_addr, 32'h14);
    sdram_cmd_done = 1'b1; sdram_rd_data = 16'h1234;
    step();
    sdram_cmd_done = 1'b0;
    settle();
    chk1("fill_done_ack",   wbs_ack,         1'b1);
    chk1("fill_ready_back", sdram_cmd_ready, 1'b1);
    step();
    sdram_cmd_accepted = 1'b0;
    settle();
    chk1("fill_empty_ready", sdram_cmd_ready, 1'b0);
    chk1("fill_ack_clear",   wbs_ack,         1'b0);
    sdram_cmd_done = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sdram_rd_data = 16'(16'h2000 + i);
      step();
      chk1 ("fill_drain_ack", wbs_ack,   1'b1);
      chk16("fill_drain_dat", wbs_dat_o, 16'(16'h2000 + i));
    end
    step();
    sdram_cmd_done = 1'b0;
    chk1("underflow_ack", wbs_ack, 1'b0);

    // outstanding limit with six reads streamed against accepts every cycle
    wbs_stb = 1'b1; wbs_we = 1'b0; sdram_cmd_accepted = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wbs_adr = 32'h200 + i;
      settle();
      chk1("lim_ready", sdram_cmd_ready, exp_rdy[i]);
      step();
    end
    wbs_stb = 1'b0;
    settle();
    chk1 ("lim_ready_low", sdram_cmd_ready, 1'b0);
    chk32("lim_head",      sdram_addr,      32'h204);
    sdram_cmd_done = 1'b1; sdram_rd_data = 16'h5A5A;
    step();
    sdram_cmd_done = 1'b0; sdram_cmd_accepted = 1'b0;
    settle();
    chk1 ("lim_ready_back", sdram_cmd_ready, 1'b1);
    chk1 ("lim_ack",        wbs_ack,         1'b1);
    chk16("lim_dat",        wbs_dat_o,       16'h5A5A);

    // bring to two queued, one outstanding, then pop + done + push together
    sdram_cmd_done = 1'b1;
    step(); step();
    sdram_cmd_done = 1'b0;
    settle();
    chk1("combo_pre_ack", wbs_ack, 1'b1);
    wbs_stb = 1'b1; wbs_adr = 32'h300; sdram_cmd_accepted = 1'b1;
    sdram_cmd_done = 1'b1; sdram_rd_data = 16'h0F0F;
    settle();
    chk1 ("combo_stall", wbs_stall,       1'b0);
    chk1 ("combo_ready", sdram_cmd_ready, 1'b1);
    chk32("combo_head",  sdram_addr,      32'h204);
    step();
    wbs_adr = 32'h301; sdram_cmd_accepted = 1'b0; sdram_cmd_done = 1'b0;
    settle();
    chk1 ("combo_ack",       wbs_ack,         1'b1);
    chk16("combo_dat",       wbs_dat_o,       16'h0F0F);
    chk32("combo_head_next", sdram_addr,      32'h205);
    chk1 ("combo_ready_on",  sdram_cmd_ready, 1'b1);
    step();
    wbs_stb = 1'b0;
    settle();
    chk1 ("combo_ack_once", wbs_ack,    1'b0);
    chk1 ("combo_occupancy", wbs_stall, 1'b0);
    chk32("combo_head_keep", sdram_addr, 32'h205);

    // abort with three queued and one in flight
    wbs_cyc = 1'b0;
    step();
    settle();
    chk1("abort_stall",  wbs_stall,       1'b1);
    chk1("abort_ready",  sdram_cmd_ready, 1'b0);
    chk1("abort_access", sdram_access,    1'b1);
    chk1("abort_ack",    wbs_ack,         1'b0);
    sdram_cmd_done = 1'b1; sdram_rd_data = 16'hDEAD;
    step();
    sdram_cmd_done = 1'b0;
    settle();
    chk1 ("abort_done_no_ack", wbs_ack,      1'b0);
    chk16("abort_dat_keep",    wbs_dat_o,    16'h0F0F);
    chk1 ("abort_still_drain", sdram_access, 1'b1);
    step();
    chk1("abort_idle_access", sdram_access, 1'b0);
    chk1("abort_idle_stall",  wbs_stall,    1'b0);
    wbs_cyc = 1'b1;
    step();
    settle();
    chk1("abort_reenter_access", sdram_access,    1'b1);
    chk1("abort_fifo_flushed",   sdram_cmd_ready, 1'b0);

    // asynchronous reset with two queued and one outstanding
    wbs_stb = 1'b1; wbs_adr = 32'h400;
    step();
    wbs_adr = 32'h401; sdram_cmd_accepted = 1'b1;
    step();
    wbs_adr = 32'h402;
    step();
    wbs_adr = 32'h403; sdram_cmd_accepted = 1'b0;
    sdram_cmd_done = 1'b1; sdram_rd_data = 16'h7777;
    step();
    wbs_stb = 1'b0; sdram_cmd_done = 1'b0;
    settle();
    chk1 ("ar_pre_ack",   wbs_ack,         1'b1);
    chk16("ar_pre_dat",   wbs_dat_o,       16'h7777);
    chk1 ("ar_pre_ready", sdram_cmd_ready, 1'b1);
    chk32("ar_pre_head",  sdram_addr,      32'h402);
    #2;
    reset = 1'b1;
    #1;
    chk1 ("ar_ack",    wbs_ack,         1'b0);
    chk16("ar_dat",    wbs_dat_o,       16'h0000);
    chk1 ("ar_access", sdram_access,    1'b0);
    chk1 ("ar_ready",  sdram_cmd_ready, 1'b0);
    chk1 ("ar_stall",  wbs_stall,       1'b0);
    wbs_cyc = 1'b0;
    step(); step();
    reset = 1'b0;
    sdram_cmd_done = 1'b1;
    step();
    sdram_cmd_done = 1'b0;
    settle();
    chk1("ar_late_done_ack", wbs_ack,      1'b0);
    chk1("ar_idle_access",   sdram_access, 1'b0);
    wbs_cyc = 1'b1; sdram_cmd_done = 1'b1;
    step();
    sdram_cmd_done = 1'b0;
    settle();
    chk1("ar_late_done_active", wbs_ack,         1'b0);
    chk1("ar_fifo_discarded",   sdram_cmd_ready, 1'b0);
    chk1("ar_active_access",    sdram_access,    1'b1);
    wbs_cyc = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
